// File: rtl/muldiv_unit.sv
// muldiv_unit -- multicycle integer multiply/divide unit for the EX stage.
// MUL is radix-2 shift-add and DIV is restoring division. Both produce one bit per
// cycle. Latency is fixed: done rises WIDTH+1 cycles after the issue cycle.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, operands are treated
// as two's complement. Magnitudes are taken at accept, and signs are applied when
// the result is written.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      issue request, sampled in IDLE/DONE
//   op_div     0 = MUL, 1 = DIV, sampled with start
//   flush      kill in-flight op; drops a coincident start
//   opa, opb   operands (multiplicand/dividend, multiplier/divisor)
//   busy       combinational stall request
//   done       one-cycle result-valid pulse
//   result     MUL: product low half; DIV: quotient
//   remainder  MUL: product high half; DIV: remainder
//   div_zero   DIV with zero divisor, valid with done
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_hi;   // MUL: accumulator high half; DIV: partial remainder
  logic [WIDTH-1:0] r_lo;   // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0] r_b;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_a;    // original dividend, returned on divide by zero

  logic             w_accept;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic             w_bz;
  logic [WIDTH-1:0] w_fin_res;
  logic [WIDTH-1:0] w_fin_rem;

  // flush beats start, and start is ignored while an op is running
  assign w_accept = start & ~flush & (r_state != S_RUN);
  assign busy     = (r_state == S_RUN) | (start & (r_state != S_RUN));
  assign w_bz     = (r_b == '0);

`ifdef MULDIV_SIGNED_EN
  logic                 r_neg_q;  // product / quotient negated
  logic                 r_neg_r;  // remainder takes dividend sign
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_s;
  logic [WIDTH-1:0]     w_q_s;
  logic [WIDTH-1:0]     w_r_s;

  assign w_a_mag = opa[WIDTH-1] ? (~opa + 1'b1) : opa;
  assign w_b_mag = opb[WIDTH-1] ? (~opb + 1'b1) : opb;
`else
  assign w_a_mag = opa;
  assign w_b_mag = opb;
`endif

  // One iteration of either algorithm
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, r_b};
    w_div_ok    = ~w_div_trial[WIDTH];
    if (r_div) begin
      // Partial remainder stays below the divisor, so WIDTH bits always hold it
      w_nxt_hi = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_nxt_lo = {r_lo[WIDTH-2:0], w_div_ok};
    end else begin
      w_nxt_hi = w_mul_sum[WIDTH:1];
      w_nxt_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Final result formed from the last iteration's output
`ifdef MULDIV_SIGNED_EN
  always_comb begin
    w_prod   = {w_nxt_hi, w_nxt_lo};
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_q_s    = r_neg_q ? (~w_nxt_lo + 1'b1) : w_nxt_lo;
    w_r_s    = r_neg_r ? (~w_nxt_hi + 1'b1) : w_nxt_hi;
    if (r_div) begin
      w_fin_res = w_bz ? {WIDTH{1'b1}} : w_q_s;
      w_fin_rem = w_bz ? r_a : w_r_s;
    end else begin
      w_fin_res = w_prod_s[WIDTH-1:0];
      w_fin_rem = w_prod_s[2*WIDTH-1:WIDTH];
    end
  end
`else
  always_comb begin
    if (r_div) begin
      w_fin_res = w_bz ? {WIDTH{1'b1}} : w_nxt_lo;
      w_fin_rem = w_bz ? r_a : w_nxt_hi;
    end else begin
      w_fin_res = w_nxt_lo;
      w_fin_rem = w_nxt_hi;
    end
  end
`endif

  // Control FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LAST_CNT) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            result    <= w_fin_res;
            remainder <= w_fin_rem;
            div_zero  <= r_div & w_bz;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new op (DONE allows back-to-back issue)
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_div   <= op_div;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Datapath registers: loaded at accept, iterated while running
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi <= '0;
      r_lo <= w_a_mag;
      r_b  <= w_b_mag;
      r_a  <= opa;
`ifdef MULDIV_SIGNED_EN
      r_neg_q <= opa[WIDTH-1] ^ opb[WIDTH-1];
      r_neg_r <= opa[WIDTH-1];
`endif
    end else if (r_state == S_RUN) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          op_div = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  remainder;
  logic          div_zero;

  int checks = 0;
  int errors = 0;

  // last expected outputs, used to verify that outputs hold
  logic [W-1:0]  m_res = '0;
  logic [W-1:0]  m_rem = '0;
  logic          m_dz  = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .flush(flush),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .remainder(remainder), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic
  task automatic model(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [W-1:0] rem, output logic z);
`ifdef MULDIV_SIGNED_EN
    int sa;
    int sb;
    int p;
    sa = $signed(a);
    sb = $signed(b);
    z  = 1'b0;
    if (!d) begin
      p   = sa * sb;
      res = p[15:0];
      rem = p[31:16];
    end else if (b == 0) begin
      res = '1; rem = a; z = 1'b1;
    end else begin
      res = 16'(sa / sb);
      rem = 16'(sa % sb);
    end
`else
    logic [31:0] p;
    z = 1'b0;
    if (!d) begin
      p   = {16'b0, a} * {16'b0, b};
      res = p[15:0];
      rem = p[31:16];
    end else if (b == 0) begin
      res = '1; rem = a; z = 1'b1;
    end else begin
      res = a / b;
      rem = a % b;
    end
`endif
  endtask

  // Issue one op in the current cycle and follow it to done.
  // chain: leave the unit in its DONE cycle so the next call issues back-to-back.
  // noise: pulse start with junk operands while running (must be ignored).
  task automatic run_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit chain, input bit noise);
    logic [W-1:0] er;
    logic [W-1:0] em;
    logic         ez;
    model(d, a, b, er, em, ez);
    start = 1'b1; op_div = d; opa = a; opb = b;
    #1;
    chk("busy_issue", busy, 1);
    tick();
    start = 1'b0;
    opa = 16'($urandom);
    opb = 16'($urandom);
    op_div = ~d;
    for (int i = 1; i <= W; i++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      start = noise && (i >= 3) && (i <= 6);
      tick();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("result", result, er);
    chk("remainder", remainder, em);
    chk("div_zero", div_zero, ez);
    m_res = er; m_rem = em; m_dz = ez;
    if (!chain) begin
      tick();
      chk("done_width", done, 0);
      chk("busy_after", busy, 0);
      chk("result_hold", result, m_res);
      chk("remainder_hold", remainder, m_rem);
    end
  endtask

  initial begin
    logic          d;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_zero", div_zero, 0);
    rst = 1'b0;
    tick();

    // Directed operations
    run_op(1'b0, 16'd3, 16'd5, 1'b0, 1'b0);
    run_op(1'b1, 16'd100, 16'd7, 1'b0, 1'b0);
    run_op(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op(1'b1, 16'd1000, 16'd3, 1'b0, 1'b0);
    run_op(1'b1, 16'hFFF9, 16'd2, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFD, 16'd4, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    run_op(1'b0, 16'h8000, 16'h0002, 1'b0, 1'b1);

    // Randomized operations, some chained and some with ignored mid-run starts
    for (int k = 0; k < 24; k++) begin
      d = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      run_op(d, a, b, (k % 3) == 1, (k % 4) == 0);
    end
    tick();

    // Flush in RUN: no done, outputs retained
    start = 1'b1; op_div = 1'b1; opa = 16'd5000; opb = 16'd9;
    #1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_result", result, m_res);
    chk("flush_remainder", remainder, m_rem);
    chk("flush_div_zero", div_zero, m_dz);
    for (int i = 0; i < 20; i++) begin
      chk("flush_no_done", done, 0);
      tick();
    end

    // flush and start together in IDLE: the start is dropped
    start = 1'b1; flush = 1'b1; op_div = 1'b0; opa = 16'd7; opb = 16'd7;
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      chk("flush_start_no_done", done, 0);
      tick();
    end

    // Unit still works after the flushes
    run_op(1'b1, 16'd12345, 16'd100, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    start = 1'b1; op_div = 1'b0; opa = 16'd77; opb = 16'd88;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_div_zero", div_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("arst_no_done", done, 0);
      tick();
    end
    run_op(1'b0, 16'd300, 16'd200, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
